// File: rtl/mars_crew_tally.sv
// mars_crew_tally
// Tally stage behind the Mars crew classifier. Accepts one 3-bit class code
// {C2,C1,C0} per candidate over a valid/ready handshake, keeps a counter per
// code, tracks the most-populated class (lowest code wins ties) and closes
// the round after CREW_SIZE legal codes. Codes 3, 5, 7 are flagged as illegal.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse: clear tallies, open a new round
//   C0, C1, C2        class code bits from the classifier
//   in_valid/in_ready handshake for the class code
//   busy, done        round open / round complete
//   bad_code          sticky flag: an illegal code was accepted
//   sel, sel_count    readout of the count for class sel
//   total             legal codes accepted this round
//   top_class/count   lowest code with the maximum count, and that count
module mars_crew_tally #(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned CREW_SIZE = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             C0,
  input  logic             C1,
  input  logic             C2,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             bad_code,
  input  logic [2:0]       sel,
  output logic [CNT_W-1:0] sel_count,
  output logic [CNT_W-1:0] total,
  output logic [2:0]       top_class,
  output logic [CNT_W-1:0] top_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [CNT_W-1:0] CREW_N = CNT_W'(CREW_SIZE);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [CNT_W-1:0] total_q, total_d;
  logic [2:0]       top_class_q, top_class_d;
  logic [CNT_W-1:0] top_count_q, top_count_d;
  logic             bad_q, bad_d;

  logic [2:0]       code;
  logic             illegal;
  logic             accept;
  logic [CNT_W-1:0] n_cnt;

  assign code    = {C2, C1, C0};
  assign illegal = C0 & (C1 | C2);

  // start blocks acceptance in the same cycle so a restart never counts
  // the code offered alongside it.
  assign in_ready = (state_q == S_COLLECT) & ~start;
  assign accept   = in_valid & in_ready;
  assign n_cnt    = cnt_q[code] + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    total_d     = total_q;
    top_class_d = top_class_q;
    top_count_d = top_count_q;
    bad_d       = bad_q;
    if (start) begin
      state_d = S_COLLECT;
      for (int unsigned i = 0; i < 8; i++) cnt_d[i] = '0;
      total_d     = '0;
      top_class_d = '0;
      top_count_d = '0;
      bad_d       = 1'b0;
    end else if (accept) begin
      if (illegal) begin
        bad_d = 1'b1;
      end else begin
        cnt_d[code] = n_cnt;
        total_d     = total_q + CNT_W'(1);
        // Incremental leader update: only the bumped class can overtake.
        if ((n_cnt > top_count_q) ||
            ((n_cnt == top_count_q) && (code < top_class_q))) begin
          top_class_d = code;
          top_count_d = n_cnt;
        end
        if (total_d == CREW_N) state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int unsigned i = 0; i < 8; i++) cnt_q[i] <= '0;
      total_q     <= '0;
      top_class_q <= '0;
      top_count_q <= '0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      top_class_q <= top_class_d;
      top_count_q <= top_count_d;
      bad_q       <= bad_d;
    end
  end

  assign busy      = (state_q == S_COLLECT);
  assign done      = (state_q == S_DONE);
  assign bad_code  = bad_q;
  assign sel_count = cnt_q[sel];
  assign total     = total_q;
  assign top_class = top_class_q;
  assign top_count = top_count_q;

endmodule

// File: tb/tb_mars_crew_tally.sv
// Self-checking bench for mars_crew_tally: a reference model builds the
// expected output snapshot for every driven cycle, queues it, and the test
// tasks pop and compare it against the DUT one cycle later.
module tb_mars_crew_tally;

  localparam int CNT_W = 4;
  localparam int CREW  = 10;

  logic             clk = 1'b0;
  logic             rst, start, C0, C1, C2, in_valid;
  logic             in_ready, busy, done, bad_code;
  logic [2:0]       sel;
  logic [CNT_W-1:0] sel_count, total, top_count;
  logic [2:0]       top_class;

  mars_crew_tally #(.CNT_W(CNT_W), .CREW_SIZE(CREW)) dut (
    .clk(clk), .rst(rst), .start(start), .C0(C0), .C1(C1), .C2(C2),
    .in_valid(in_valid), .in_ready(in_ready), .busy(busy), .done(done),
    .bad_code(bad_code), .sel(sel), .sel_count(sel_count), .total(total),
    .top_class(top_class), .top_count(top_count)
  );

  always #5 clk = ~clk;

  // {busy, done, bad_code, total, top_class, top_count}
  typedef logic [13:0] snap_t;
  snap_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state: 0 idle, 1 collect, 2 done
  int mcnt [8];
  int mtotal, mstate;
  bit mbad;
  logic rdy_pre;

  function automatic snap_t model_snap();
    int best = 0;
    int cls  = 0;
    for (int k = 0; k < 8; k++)
      if (mcnt[k] > best) begin best = mcnt[k]; cls = k; end
    return {mstate == 1, mstate == 2, mbad, 4'(mtotal), 3'(cls), 4'(best)};
  endfunction

  function automatic snap_t dut_snap();
    return {busy, done, bad_code, total, top_class, top_count};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) mcnt[k] = 0;
    mtotal = 0;
    mbad   = 1'b0;
  endtask

  // Drive one cycle; rdy_pre is in_ready sampled after the drive, before the edge.
  task automatic step(input logic st, input logic v, input logic [2:0] k);
    bit acc;
    @(negedge clk);
    start = st; in_valid = v; {C2, C1, C0} = k;
    #1 rdy_pre = in_ready;
    acc = v && (mstate == 1) && !st;
    if (st) begin
      model_clear();
      mstate = 1;
    end else if (acc) begin
      if (k == 3'd3 || k == 3'd5 || k == 3'd7) mbad = 1'b1;
      else begin
        mcnt[k]++;
        mtotal++;
        if (mtotal == CREW) mstate = 2;
      end
    end
    sb.push_back(model_snap());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t e;
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; {C2, C1, C0} = 3'd0; sel = 3'd0;
    model_clear(); mstate = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dut_snap(), in_ready, sel_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {dut_snap(), in_ready, sel_count});
    end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 3'd2);
      e = sb.pop_front();
      checks++;
      if (dut_snap() !== e || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL idle_ignore got=%h/%b want=%h/0", dut_snap(), in_ready, e);
      end
    end
  endtask

  task automatic test_full_round();
    logic [2:0] codes [10] = '{3'd2, 3'd2, 3'd4, 3'd0, 3'd2, 3'd1, 3'd4, 3'd6, 3'd0, 3'd2};
    snap_t e;
    step(1'b1, 1'b0, 3'd0);
    e = sb.pop_front();
    checks++;
    if (dut_snap() !== e) begin
      failures++;
      $display("FAIL round_start got=%h want=%h", dut_snap(), e);
    end
    foreach (codes[i]) begin
      step(1'b0, 1'b1, codes[i]);
      e = sb.pop_front();
      checks++;
      if (dut_snap() !== e || rdy_pre !== 1'b1) begin
        failures++;
        $display("FAIL round_accept%0d got=%h/%b want=%h/1", i, dut_snap(), rdy_pre, e);
      end
    end
    checks++;
    if ({done, busy, total, top_class, top_count} !== {1'b1, 1'b0, 4'd10, 3'd2, 4'd4}) begin
      failures++;
      $display("FAIL round_final got=%b%b t=%0d c=%0d n=%0d want=10 10 2 4",
               done, busy, total, top_class, top_count);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 3'd2);
      e = sb.pop_front();
      checks++;
      if (dut_snap() !== e || rdy_pre !== 1'b0) begin
        failures++;
        $display("FAIL done_hold got=%h/%b want=%h/0", dut_snap(), rdy_pre, e);
      end
    end
  endtask

  task automatic test_readout();
    int want [8] = '{2, 1, 4, 0, 2, 0, 1, 0};
    @(negedge clk) in_valid = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      checks++;
      if (sel_count !== 4'(want[s]) || sel_count !== 4'(mcnt[s])) begin
        failures++;
        $display("FAIL readout_sel%0d got=%0d want=%0d", s, sel_count, want[s]);
      end
    end
  endtask

  task automatic test_tie();
    logic [2:0] codes [3] = '{3'd4, 3'd1, 3'd4};
    logic [2:0] wcls  [3] = '{3'd4, 3'd1, 3'd4};
    logic [3:0] wcnt  [3] = '{4'd1, 4'd1, 4'd2};
    snap_t e;
    step(1'b1, 1'b0, 3'd0);
    e = sb.pop_front();
    checks++;
    if (dut_snap() !== e) begin
      failures++;
      $display("FAIL tie_start got=%h want=%h", dut_snap(), e);
    end
    foreach (codes[i]) begin
      step(1'b0, 1'b1, codes[i]);
      e = sb.pop_front();
      checks++;
      if (dut_snap() !== e || top_class !== wcls[i] || top_count !== wcnt[i]) begin
        failures++;
        $display("FAIL tie_step%0d got=%h c=%0d n=%0d want=%h c=%0d n=%0d",
                 i, dut_snap(), top_class, top_count, e, wcls[i], wcnt[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0] codes [5] = '{3'd5, 3'd1, 3'd3, 3'd7, 3'd0};
    snap_t e;
    step(1'b1, 1'b0, 3'd0);
    void'(sb.pop_front());
    foreach (codes[i]) begin
      step(1'b0, 1'b1, codes[i]);
      e = sb.pop_front();
      checks++;
      if (dut_snap() !== e || bad_code !== 1'b1) begin
        failures++;
        $display("FAIL illegal_step%0d got=%h bad=%b want=%h bad=1", i, dut_snap(), bad_code, e);
      end
    end
    checks++;
    if (total !== 4'd2) begin
      failures++;
      $display("FAIL illegal_total got=%0d want=2", total);
    end
    step(1'b1, 1'b0, 3'd0);
    e = sb.pop_front();
    checks++;
    if (dut_snap() !== e || bad_code !== 1'b0) begin
      failures++;
      $display("FAIL illegal_clear got=%h want=%h", dut_snap(), e);
    end
  endtask

  task automatic test_restart();
    snap_t e;
    step(1'b0, 1'b1, 3'd2);
    step(1'b0, 1'b1, 3'd6);
    void'(sb.pop_front());
    void'(sb.pop_front());
    step(1'b1, 1'b1, 3'd6);
    e = sb.pop_front();
    checks++;
    if (rdy_pre !== 1'b0) begin
      failures++;
      $display("FAIL restart_ready got=%b want=0", rdy_pre);
    end
    checks++;
    if (dut_snap() !== e || dut_snap() !== {1'b1, 13'd0}) begin
      failures++;
      $display("FAIL restart_clear got=%h want=%h", dut_snap(), e);
    end
  endtask

  task automatic test_back_to_back();
    snap_t e;
    // Alternate accepts with idle cycles, then reset mid-round with start high.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i % 2) == 0, 3'(i * 2));
      e = sb.pop_front();
      checks++;
      if (dut_snap() !== e) begin
        failures++;
        $display("FAIL b2b_step%0d got=%h want=%h", i, dut_snap(), e);
      end
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    model_clear(); mstate = 0;
    checks++;
    if ({dut_snap(), in_ready} !== '0) begin
      failures++;
      $display("FAIL midround_reset got=%h/%b want=0", dut_snap(), in_ready);
    end
    @(negedge clk) rst = 1'b0; start = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; C0 = 1'b0; C1 = 1'b0; C2 = 1'b0;
    sel = 3'd0; rdy_pre = 1'b0;
    model_clear(); mstate = 0;
    test_reset();
    test_full_round();
    test_readout();
    test_tie();
    test_illegal();
    test_restart();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
